pll_rst_ctrl: RTL and testbench

Reset sequencer between the board reset pin, the clock PLL and the SoC core.
- Drives the PLL's active-high reset.
- Monitors the PLL lock output and filters it.
- Releases an active-low system reset only after lock has been stable for a programmable time.
- Runs on the PLL reference clock (50 MHz board oscillator), because PLL outputs are invalid before lock.

---
 rtl/pll_rst_ctrl.sv | 154 +++++++++++++++
 tb/tb_pll_rst_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_ctrl.sv
// rtl/pll_rst_ctrl.sv - PLL reset pulse, lock filtering and system reset release sequencer
// Optional: PLL_RST_CTRL_RELOCK_EN re-pulses the PLL on lock loss in RUN (default: re-wait for lock).
module pll_rst_ctrl #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_FILTER    = 8,
   parameter int HOLD_CYCLES    = 256,
   parameter int LOCK_TIMEOUT   = 65536
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pll_locked_i,
   output logic       pll_rst_o,
   output logic       sys_rst_no,
   output logic       ready_o,
   output logic [7:0] retry_cnt_o
);

   localparam int MAX_A = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
   localparam int MAX_B = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P) + 1;
   localparam int TW    = $clog2(LOCK_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_FILTER    = 3'd2,
      S_HOLD      = 3'd3,
      S_RUN       = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    retry_q, retry_d;
   logic          sync1_q, lk_q;
   logic          pll_rst_q, pll_rst_d;
   logic          sys_rst_n_q, sys_rst_n_d;
   logic          ready_q, ready_d;
   logic          timeout;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         sync1_q     <= 1'b0;
         lk_q        <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         sync1_q     <= pll_locked_i;
         lk_q        <= sync1_q;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
      end
   end

   assign timeout = (tmo_q == TW'(LOCK_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      case (state_q)
         S_PLL_RST: begin
            tmo_d = '0;
            if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_LOCK, S_FILTER: begin
            tmo_d = tmo_q + TW'(1);
            // Timeout wins over any lock activity seen in the same cycle
            if (timeout) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
               tmo_d   = '0;
               if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end else if (state_q == S_WAIT_LOCK) begin
               if (lk_q) begin
                  if (LOCK_FILTER == 1) begin
                     state_d = S_HOLD;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_FILTER;
                     cnt_d   = CW'(1);
                  end
               end
            end else if (!lk_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (!lk_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
               tmo_d   = '0;
            end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (!lk_q) begin
`ifdef PLL_RST_CTRL_RELOCK_EN
               state_d = S_PLL_RST;
`else
               state_d = S_WAIT_LOCK;
`endif
               cnt_d = '0;
               tmo_d = '0;
            end
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            tmo_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_comb begin
      pll_rst_d   = (state_d == S_PLL_RST);
      sys_rst_n_d = (state_d == S_RUN);
      ready_d     = (state_d == S_RUN);
   end

   assign pll_rst_o   = pll_rst_q;
   assign sys_rst_no  = sys_rst_n_q;
   assign ready_o     = ready_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb/tb_pll_rst_ctrl.sv - scoreboard bench for pll_rst_ctrl (4/3/10/50 configuration)
module tb_pll_rst_ctrl;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [7:0] retry;

   typedef struct {
      int          c;
      logic [10:0] v;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         e;
   int          cyc;
   int          checks;
   int          errors;
   bit          mon_en;
   logic [10:0] cur;
   logic [10:0] prev;
   logic [7:0]  exp_retry;
   int          r, t, g, a, h, fall;

   pll_rst_ctrl #(
      .PLL_RST_CYCLES(4),
      .LOCK_FILTER   (3),
      .HOLD_CYCLES   (10),
      .LOCK_TIMEOUT  (50)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pll_locked_i(locked),
      .pll_rst_o   (pll_rst),
      .sys_rst_no  (sys_rst_n),
      .ready_o     (ready),
      .retry_cnt_o (retry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every observed output change must match the next queued expectation
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {pll_rst, sys_rst_n, ready, retry};
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.c != cyc || e.v !== cur) begin
                  errors++;
                  $display("FAIL output_event got cyc=%0d val=%b required cyc=%0d val=%b",
                           cyc, cur, e.c, e.v);
               end
            end
            prev = cur;
         end
      end
   end

   task automatic push(input int c, input logic p, input logic s, input logic rd, input logic [7:0] n);
      ev_t x;
      x.c = c;
      x.v = {p, s, rd, n};
      exp_q.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", nm, got, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      push(cyc, 1'b1, 1'b0, 1'b0, 8'd0);
      #1;
      chk("async_pll_rst", {7'd0, pll_rst}, 8'd1);
      chk("async_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
      chk("async_retry", retry, 8'd0);
      locked    = 1'b0;
      exp_retry = 8'd0;
      step(2);
   endtask

   task automatic do_release(output int rel);
      rst_n = 1'b1;
      rel   = cyc;
      push(rel + 4, 1'b0, 1'b0, 1'b0, exp_retry);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d required=sequence complete", cyc);
      $fatal(1);
   end

   initial begin
      checks    = 0;
      errors    = 0;
      mon_en    = 1'b0;
      exp_retry = 8'd0;
      rst_n     = 1'b1;
      locked    = 1'b0;
      #2 rst_n  = 1'b0;
      #1;
      chk("reset_pll_rst", {7'd0, pll_rst}, 8'd1);
      chk("reset_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
      chk("reset_ready", {7'd0, ready}, 8'd0);
      chk("reset_retry", retry, 8'd0);
      prev   = {1'b1, 1'b0, 1'b0, 8'd0};
      mon_en = 1'b1;
      step(2);

      // Power-up: lock 5 cycles after PLL reset falls, release 2+3+10 later
      do_release(r);
      wait_until(r + 9);
      locked = 1'b1;
      t = cyc;
      push(t + 15, 1'b0, 1'b1, 1'b1, exp_retry);
      wait_until(t + 20);

      // Lock loss in RUN
      locked = 1'b0;
      t = cyc;
`ifdef PLL_RST_CTRL_RELOCK_EN
      push(t + 3, 1'b1, 1'b0, 1'b0, exp_retry);
      push(t + 7, 1'b0, 1'b0, 1'b0, exp_retry);
      fall = t + 7;
`else
      push(t + 3, 1'b0, 1'b0, 1'b0, exp_retry);
      exp_retry = exp_retry + 8'd1;
      push(t + 53, 1'b1, 1'b0, 1'b0, exp_retry);
      push(t + 57, 1'b0, 1'b0, 1'b0, exp_retry);
      fall = t + 57;
`endif
      wait_until(fall + 2);
      locked = 1'b1;
      t = cyc;
      push(t + 15, 1'b0, 1'b1, 1'b1, exp_retry);
      wait_until(t + 20);

      // Reset in RUN, then a 2-cycle lock glitch before a real lock
      do_reset();
      do_release(r);
      wait_until(r + 6);
      g = cyc;
      locked = 1'b1;
      step(2);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      push(g + 18, 1'b0, 1'b1, 1'b1, 8'd0);
      wait_until(g + 23);

      // Lock drops for 3 cycles in HOLD; hold restarts in full
      do_reset();
      do_release(r);
      wait_until(r + 6);
      a = cyc;
      locked = 1'b1;
      wait_until(a + 7);
      h = cyc;
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      push(h + 18, 1'b0, 1'b1, 1'b1, 8'd0);
      wait_until(h + 23);

      // Reset in RUN, relock, then reset mid-HOLD
      do_reset();
      do_release(r);
      wait_until(r + 6);
      a = cyc;
      locked = 1'b1;
      wait_until(a + 9);
      do_reset();

      // No lock ever: PLL re-pulsed every 54 cycles, retry counts 1,2,3
      do_release(r);
      for (int k = 1; k <= 3; k++) begin
         push(r + 54 * k, 1'b1, 1'b0, 1'b0, 8'(k));
         push(r + 54 * k + 4, 1'b0, 1'b0, 1'b0, 8'(k));
      end
      wait_until(r + 3 * 54 + 14);
      chk("nolock_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
      chk("nolock_retry", retry, 8'd3);
      step(5);
      chk("pending_events", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
